// File: rtl/demux_16_2.sv
// demux_16_2: registered 1-to-2 valid/ready demultiplexer with per-channel holding registers; optional statistics via DEMUX_STATS_EN
module demux_16_2 #(
  parameter int WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t st0, st1, st0_n, st1_n;
  logic load0, load1, drain0, drain1;
  // handshake decode; ready follows the selected channel even when in_valid is low
  always_comb begin
    out0_valid = st0 == FULL;
    out1_valid = st1 == FULL;
    drain0     = out0_valid && out0_ready;
    drain1     = out1_valid && out1_ready;
    in_ready   = !rst && (in_sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready));
    load0      = in_valid && in_ready && !in_sel;
    load1      = in_valid && in_ready && in_sel;
    st0_n      = load0 ? FULL : drain0 ? EMPTY : st0;
    st1_n      = load1 ? FULL : drain1 ? EMPTY : st1;
  end
  // channel state and holding registers; a load during drain refills without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      st0       <= EMPTY;
      st1       <= EMPTY;
      out0_data <= '0;
      out1_data <= '0;
    end else begin
      st0 <= st0_n;
      st1 <= st1_n;
      if (load0) out0_data <= in_data;
      if (load1) out1_data <= in_data;
    end
  end
`ifdef DEMUX_STATS_EN
  // per-channel accept counters wrap; stall counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0      <= '0;
      cnt1      <= '0;
      stall_cnt <= '0;
    end else begin
      cnt0 <= cnt0 + CNT_WIDTH'(load0);
      cnt1 <= cnt1 + CNT_WIDTH'(load1);
      if (in_valid && !in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_demux_16_2.sv
// tb_demux_16_2: directed self-checking bench for demux_16_2
module tb_demux_16_2;
  logic clk, rst;
  logic [15:0] in_data, out0_data, out1_data;
  logic in_sel, in_valid, in_ready, out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0, cnt1, stall_cnt;
`endif
  int errors = 0;
  int checks = 0;

  demux_16_2 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready)
`ifdef DEMUX_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    in_valid = v;
    in_sel = s;
    in_data = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    out0_ready = 1;
    out1_ready = 1;
    drive(1, 0, 16'h1234);
    step();
    step();
    checks += 5;
    if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_v0 got=%b exp=0", out0_valid); end
    if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_v1 got=%b exp=0", out1_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    if (out0_data !== 16'h0) begin errors++; $display("FAIL reset_d0 got=%h exp=0000", out0_data); end
    if (out1_data !== 16'h0) begin errors++; $display("FAIL reset_d1 got=%h exp=0000", out1_data); end
    rst = 0;
    drive(0, 0, 16'h0);
  endtask

  task automatic test_route();
    out0_ready = 1;
    out1_ready = 1;
    drive(1, 0, 16'hFFFF);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready got=%b exp=1", in_ready); end
    step();
    drive(1, 1, 16'h0000);
    checks += 3;
    if (out0_valid !== 1'b1) begin errors++; $display("FAIL route_v0 got=%b exp=1", out0_valid); end
    if (out0_data !== 16'hFFFF) begin errors++; $display("FAIL route_d0 got=%h exp=ffff", out0_data); end
    if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_v1_idle got=%b exp=0", out1_valid); end
    step();
    drive(0, 0, 16'h0);
    checks += 3;
    if (out0_valid !== 1'b0) begin errors++; $display("FAIL route_v0_drop got=%b exp=0", out0_valid); end
    if (out1_valid !== 1'b1) begin errors++; $display("FAIL route_v1 got=%b exp=1", out1_valid); end
    if (out1_data !== 16'h0000) begin errors++; $display("FAIL route_d1 got=%h exp=0000", out1_data); end
    step();
    checks++;
    if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_v1_drop got=%b exp=0", out1_valid); end
  endtask

  task automatic test_stall();
    out0_ready = 0;
    out1_ready = 1;
    drive(1, 0, 16'hA5A5);
    step();
    drive(1, 0, 16'h5A5A);
    checks += 3;
    if (out0_data !== 16'hA5A5) begin errors++; $display("FAIL stall_d0 got=%h exp=a5a5", out0_data); end
    if (out0_valid !== 1'b1) begin errors++; $display("FAIL stall_v0 got=%b exp=1", out0_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
    step();
    drive(1, 1, 16'h1234);
    checks += 2;
    if (out0_data !== 16'hA5A5) begin errors++; $display("FAIL stall_hold got=%h exp=a5a5", out0_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_other_ready got=%b exp=1", in_ready); end
    step();
    drive(0, 0, 16'h0);
    checks += 4;
    if (out1_valid !== 1'b1) begin errors++; $display("FAIL stall_v1 got=%b exp=1", out1_valid); end
    if (out1_data !== 16'h1234) begin errors++; $display("FAIL stall_d1 got=%h exp=1234", out1_data); end
    if (out0_data !== 16'hA5A5) begin errors++; $display("FAIL stall_hold2 got=%h exp=a5a5", out0_data); end
    if (out0_valid !== 1'b1) begin errors++; $display("FAIL stall_v0_hold got=%b exp=1", out0_valid); end
    out0_ready = 1;
    step();
    checks += 2;
    if (out0_valid !== 1'b0) begin errors++; $display("FAIL stall_drain0 got=%b exp=0", out0_valid); end
    if (out1_valid !== 1'b0) begin errors++; $display("FAIL stall_drain1 got=%b exp=0", out1_valid); end
  endtask

  task automatic test_back_to_back();
    out1_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 16'(i));
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      checks += 2;
      if (out1_valid !== 1'b1) begin errors++; $display("FAIL b2b_v1[%0d] got=%b exp=1", i, out1_valid); end
      if (out1_data !== 16'(i)) begin errors++; $display("FAIL b2b_d1[%0d] got=%h exp=%h", i, out1_data, 16'(i)); end
    end
    drive(0, 0, 16'h0);
    step();
    checks++;
    if (out1_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", out1_valid); end
  endtask

  task automatic test_reset_midop();
    out0_ready = 0;
    out1_ready = 0;
    drive(1, 0, 16'h1111);
    step();
    drive(1, 1, 16'h2222);
    step();
    drive(0, 0, 16'h0);
    checks += 2;
    if (out0_valid !== 1'b1) begin errors++; $display("FAIL mid_full0 got=%b exp=1", out0_valid); end
    if (out1_valid !== 1'b1) begin errors++; $display("FAIL mid_full1 got=%b exp=1", out1_valid); end
    rst = 1;
    step();
    rst = 0;
    checks += 2;
    if (out0_valid !== 1'b0) begin errors++; $display("FAIL mid_v0 got=%b exp=0", out0_valid); end
    if (out1_valid !== 1'b0) begin errors++; $display("FAIL mid_v1 got=%b exp=0", out1_valid); end
    out0_ready = 1;
    out1_ready = 1;
    drive(1, 1, 16'h00FF);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
    step();
    drive(0, 0, 16'h0);
    checks += 2;
    if (out1_valid !== 1'b1) begin errors++; $display("FAIL mid_post_v1 got=%b exp=1", out1_valid); end
    if (out1_data !== 16'h00FF) begin errors++; $display("FAIL mid_post_d1 got=%h exp=00ff", out1_data); end
    step();
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (cnt0 !== 16'd0) begin errors++; $display("FAIL stats_clr got=%0d exp=0", cnt0); end
    out0_ready = 0;
    out1_ready = 1;
    drive(1, 0, 16'h0001);
    step();
    for (int i = 0; i < 4; i++) step();
    out0_ready = 1;
    #1;
    step();
    step();
    drive(1, 1, 16'h0002);
    step();
    step();
    drive(0, 0, 16'h0);
    checks += 3;
    if (cnt0 !== 16'd3) begin errors++; $display("FAIL stats_cnt0 got=%0d exp=3", cnt0); end
    if (cnt1 !== 16'd2) begin errors++; $display("FAIL stats_cnt1 got=%0d exp=2", cnt1); end
    if (stall_cnt !== 16'd4) begin errors++; $display("FAIL stats_stall got=%0d exp=4", stall_cnt); end
    step();
  endtask
`endif

  initial begin
    rst = 1;
    in_valid = 0;
    in_sel = 0;
    in_data = 0;
    out0_ready = 1;
    out1_ready = 1;
    test_reset();
    test_route();
    test_stall();
    test_back_to_back();
    test_reset_midop();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
